key_expansion_seq: RTL and testbench

Sequential AES key-schedule engine supporting AES-128, AES-192 and AES-256. Key size is selected at run time rather than by elaboration parameter. It latches a cipher key on a start handshake, generates one 32-bit schedule word per clock, and stores the full schedule in an internal word RAM. The cipher datapath reads round keys from that RAM through a registered read port. Each new word is also streamed out with a valid strobe for monitoring and verification.

---
 rtl/key_expansion_seq.sv | 154 +++++++++++++++
 tb/tb_key_expansion_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_seq.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per clock into an internal
// word store, with a registered read port and a streamed copy of each new word.
`timescale 1ns/1ps
module key_expansion_seq #(
  parameter int unsigned MAX_WORDS = 60,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        key_size,
  input  logic [255:0]      key_in,
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  output logic              size_err,
  output logic              word_valid,
  output logic [ADDR_W-1:0] word_idx,
  output logic [31:0]       word_out,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  typedef enum logic {IDLE, EXPAND} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t            r_state, w_next;
  logic [1:0]        r_ks;
  logic [ADDR_W-1:0] r_wt, r_i;
  logic [2:0]        r_mod;
  logic [7:0]        r_rcon;
  logic [31:0]       r_win [8];
  logic [31:0]       r_mem [MAX_WORDS];

  logic              w_accept, w_last;
  logic [3:0]        w_nk_in;
  logic [ADDR_W-1:0] w_wt_in;
  logic [2:0]        w_nk_m1;
  logic [31:0]       w_key [8];
  logic [31:0]       w_prev, w_old, w_t, w_new;

  assign w_accept = (r_state == IDLE) && start && (key_size != 2'b11);
  assign w_last   = (r_state == EXPAND) && (r_i == r_wt - 1'b1);

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) w_key[k] = key_in[255 - 32*k -: 32];
    unique case (key_size)
      2'b00:   begin w_nk_in = 4'd4; w_wt_in = ADDR_W'(44); end
      2'b01:   begin w_nk_in = 4'd6; w_wt_in = ADDR_W'(52); end
      default: begin w_nk_in = 4'd8; w_wt_in = ADDR_W'(60); end
    endcase
  end

  // r_win[0] = w[i-1] ... r_win[Nk-1] = w[i-Nk]; a shift window avoids RAM reads
  always_comb begin
    w_prev = r_win[0];
    unique case (r_ks)
      2'b00:   begin w_old = r_win[3]; w_nk_m1 = 3'd3; end
      2'b01:   begin w_old = r_win[5]; w_nk_m1 = 3'd5; end
      default: begin w_old = r_win[7]; w_nk_m1 = 3'd7; end
    endcase
    if (r_mod == 3'd0)
      w_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    else if (r_ks == 2'b10 && r_mod == 3'd4)
      w_t = sub_word(w_prev);
    else
      w_t = w_prev;
    w_new = w_old ^ w_t;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_next = EXPAND;
      EXPAND: if (w_last)   w_next = IDLE;
      default:              w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == EXPAND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ks <= '0; r_wt <= '0; r_i <= '0; r_mod <= '0; r_rcon <= '0;
      for (int unsigned j = 0; j < 8; j++) r_win[j] <= '0;
      done <= 1'b0; keys_valid <= 1'b0; size_err <= 1'b0; word_valid <= 1'b0;
      word_idx <= '0; word_out <= '0; rd_data <= '0;
    end else begin
      done       <= 1'b0;
      size_err   <= (r_state == IDLE) && start && (key_size == 2'b11);
      word_valid <= (r_state == EXPAND);
      rd_data    <= (rd_addr >= r_wt) ? '0 : r_mem[rd_addr];
      if (w_accept) begin
        r_ks <= key_size; r_wt <= w_wt_in; r_i <= ADDR_W'(w_nk_in);
        r_mod <= '0; r_rcon <= 8'h01; keys_valid <= 1'b0;
        for (int unsigned j = 0; j < 8; j++) r_win[j] <= '0;
        unique case (key_size)
          2'b00:   for (int unsigned j = 0; j < 4; j++) r_win[j] <= w_key[3-j];
          2'b01:   for (int unsigned j = 0; j < 6; j++) r_win[j] <= w_key[5-j];
          default: for (int unsigned j = 0; j < 8; j++) r_win[j] <= w_key[7-j];
        endcase
      end else if (r_state == EXPAND) begin
        r_win[0] <= w_new;
        for (int unsigned j = 1; j < 8; j++) r_win[j] <= r_win[j-1];
        if (r_mod == 3'd0) r_rcon <= xtime(r_rcon);
        r_mod    <= (r_mod == w_nk_m1) ? 3'd0 : r_mod + 3'd1;
        r_i      <= r_i + 1'b1;
        word_idx <= r_i;
        word_out <= w_new;
        done     <= w_last;
        if (w_last) keys_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int unsigned k = 0; k < 8; k++)
        if (k < 32'(w_nk_in)) r_mem[k] <= w_key[k];
    end else if (r_state == EXPAND) begin
      r_mem[r_i] <= w_new;
    end
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: a reference key schedule built on an
// S-box derived from GF(2^8) inversion, plus FIPS-197 vectors and directed corner cases.
`timescale 1ns/1ps
module tb_key_expansion_seq;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [1:0]   key_size = '0;
  logic [255:0] key_in = '0;
  logic [5:0]   rd_addr = '0;
  logic         busy, done, keys_valid, size_err, word_valid;
  logic [5:0]   word_idx;
  logic [31:0]  word_out, rd_data;

  key_expansion_seq #(.MAX_WORDS(60), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .key_size(key_size), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid), .size_err(size_err),
    .word_valid(word_valid), .word_idx(word_idx), .word_out(word_out),
    .rd_addr(rd_addr), .rd_data(rd_data));

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  logic [37:0] sbq[$];
  logic [37:0] mon_e;
  logic [31:0] g [60];
  logic [7:0]  sb [256];
  logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hcafef00dcafef00d};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KA   = 256'h000102030405060708090a0b0c0d0e0f_5555aaaa5555aaaa5555aaaa5555aaaa;
  localparam logic [255:0] KB   = 256'hfedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_1122334455667788;
  localparam logic [255:0] KC   = 256'hffffffff00000000ffffffff00000000_13579bdf2468ace013579bdf2468ace0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0]  v = 8'h01;
    logic [15:0] d;
    for (int k = 0; k < 254; k++) v = gmul(v, x);
    d = {v, v};
    return v ^ d[14 -: 8] ^ d[13 -: 8] ^ d[12 -: 8] ^ d[11 -: 8] ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic int nk_of(input logic [1:0] ks);
    return (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : 8;
  endfunction

  function automatic int wt_of(input logic [1:0] ks);
    return (ks == 2'b00) ? 44 : (ks == 2'b01) ? 52 : 60;
  endfunction

  task automatic expand(input logic [255:0] key, input logic [1:0] ks);
    int nk = nk_of(ks);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) g[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < wt_of(ks); i++) begin
      t = g[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
      else if (nk == 8 && i % 8 == 4) t = subw(t);
      g[i] = g[i-nk] ^ t;
    end
  endtask

  task automatic push_gold(input logic [255:0] key, input logic [1:0] ks);
    expand(key, ks);
    for (int i = nk_of(ks); i < wt_of(ks); i++) sbq.push_back({6'(i), g[i]});
  endtask

  // Drives one start (optionally held, optionally re-pulsed mid-run) and follows it to done.
  task automatic do_run(input logic [255:0] key, input logic [1:0] ks, input bit hold, input int rp);
    int nk = nk_of(ks), wt = wt_of(ks), cnt;
    start = 1'b1; key_size = ks; key_in = key;
    push_gold(key, ks);
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("keys_valid_cleared", keys_valid, 0);
    chk("no_word_at_accept", word_valid, 0);
    @(negedge clk); cnt = 1;
    chk("first_valid", word_valid, 1);
    chk("first_idx", word_idx, nk);
    chk("first_word", word_out, g[nk]);
    while (!done && cnt < 100) begin
      if (cnt == rp) begin start = 1'b1; key_in = ~key; key_size = 2'b10; end
      else if (cnt == rp + 2) begin start = hold; key_in = key; key_size = ks; end
      @(negedge clk); cnt++;
    end
    chk("done_latency", cnt, wt - nk);
    chk("last_idx", word_idx, wt - 1);
    chk("last_word", word_out, g[wt-1]);
    chk("busy_with_done", busy, 0);
    chk("keys_valid_set", keys_valid, 1);
    #1;
    chk("sb_drained", sbq.size(), 0);
  endtask

  task automatic read_chk(input logic [5:0] a, input logic [31:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk("rd_data", {a, rd_data}, {a, exp});
  endtask

  task automatic read_all(input int wt);
    for (int k = 0; k < wt; k++) read_chk(6'(k), g[k]);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_busy", busy, 0);             chk("rst_done", done, 0);
    chk("rst_keys_valid", keys_valid, 0); chk("rst_size_err", size_err, 0);
    chk("rst_word_valid", word_valid, 0); chk("rst_word_idx", word_idx, 0);
    chk("rst_word_out", word_out, 0);     chk("rst_rd_data", rd_data, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && word_valid) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("sb_word_idx", word_idx, mon_e[37:32]);
        chk("sb_word_out", word_out, mon_e[31:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int x = 0; x < 256; x++) sb[x] = ref_sbox(8'(x));
    repeat (3) @(negedge clk);
    chk_outputs_zero();
    reset = 1'b0;
    @(negedge clk);

    do_run(K128, 2'b00, 1'b0, -1);
    chk("aes128_w43_out", word_out, 32'hb6630ca6);
    read_chk(6'd43, 32'hb6630ca6);
    read_chk(6'd4, 32'ha0fafe17);
    read_all(44);

    do_run(K192, 2'b01, 1'b0, -1);
    read_chk(6'd6, 32'hfe0c91f7);
    read_chk(6'd51, 32'h01002202);
    read_chk(6'd52, 32'h0);
    read_all(52);

    do_run(K256, 2'b10, 1'b0, -1);
    read_chk(6'd8, 32'h9ba35411);
    read_chk(6'd59, 32'h706c631e);
    read_chk(6'd63, 32'h0);
    read_all(60);

    start = 1'b1; key_size = 2'b11; key_in = ~K256;
    @(negedge clk);
    start = 1'b0;
    chk("size_err_pulse", size_err, 1);
    chk("size_err_busy", busy, 0);
    chk("size_err_keys_valid", keys_valid, 1);
    @(negedge clk);
    chk("size_err_single", size_err, 0);
    chk("size_err_idle", busy, 0);
    read_chk(6'd59, 32'h706c631e);
    read_chk(6'd0, 32'h603deb10);

    do_run(K128, 2'b00, 1'b0, 10);
    read_chk(6'd43, 32'hb6630ca6);

    start = 1'b1; key_size = 2'b01; key_in = K192;
    push_gold(K192, 2'b01);
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    #2;
    sbq.delete();
    reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero();
    reset = 1'b0;
    read_chk(6'd0, 32'h0);
    do_run(K128, 2'b00, 1'b0, -1);
    read_all(44);

    do_run(KA, 2'b00, 1'b1, -1);
    do_run(KB, 2'b10, 1'b1, -1);
    do_run(KC, 2'b00, 1'b1, -1);
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_release", busy, 0);
    read_all(44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
